// File: rtl/ti_stage1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ti_stage1_pipe (with leaf cells gf24mul, sqsc)
// Description : Pipelined multi-lane 2-share threshold-implementation stage
//               for the GF(2^4) inverter of a masked AES S-box. Stage A
//               forms four refreshed product shares per lane; stage B
//               compresses them to two output shares. Valid/ready on both
//               sides plus a randomness handshake.
//               GF(2^4) is polynomial basis mod x^4+x+1; SqSc(x) = x^2 * x^3.
// Option      : `define TI_STAGE1_PRECHARGE_EN to zero regA/regB whenever
//               they hold no valid data (all-zero separation between values).
// Revision    : 1.0  initial release
// ============================================================================

// GF(2^4) multiplier, polynomial basis, reduction by x^4 = x + 1.
module gf24mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);
  logic [6:0] w_pp;

  // Unreduced carry-less product coefficients.
  always_comb begin
    w_pp[0] = a[0] & b[0];
    w_pp[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    w_pp[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
    w_pp[3] = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ (a[0] & b[3]);
    w_pp[4] = (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
    w_pp[5] = (a[3] & b[2]) ^ (a[2] & b[3]);
    w_pp[6] = a[3] & b[3];
  end

  // x^4 -> x+1, x^5 -> x^2+x, x^6 -> x^3+x^2
  assign p[0] = w_pp[0] ^ w_pp[4];
  assign p[1] = w_pp[1] ^ w_pp[4] ^ w_pp[5];
  assign p[2] = w_pp[2] ^ w_pp[5] ^ w_pp[6];
  assign p[3] = w_pp[3] ^ w_pp[6];
endmodule

// Square-and-scale: y = x^2 * x^3 in GF(2^4). Linear over GF(2), which is
// what lets it be applied share-wise.
module sqsc (
  input  logic [3:0] x,
  output logic [3:0] y
);
  assign y[0] = x[2];
  assign y[1] = x[1] ^ x[2] ^ x[3];
  assign y[2] = x[1];
  assign y[3] = x[0] ^ x[2] ^ x[3];
endmodule

module ti_stage1_pipe #(
  parameter int NLANES = 4,
  parameter bit SQSC   = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NLANES-1:0]    a0,
  input  logic [4*NLANES-1:0]    a1,
  input  logic [4*NLANES-1:0]    b0,
  input  logic [4*NLANES-1:0]    b1,
  input  logic [12*NLANES-1:0]   rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NLANES-1:0]    q0,
  output logic [4*NLANES-1:0]    q1,
  output logic                   busy
);
  localparam int c_width = 4 * NLANES;

  logic                 r_va, r_vb;
  logic [c_width-1:0]   r_e0, r_e1, r_e2, r_e3;
  logic [c_width-1:0]   r_q0, r_q1;
  logic [c_width-1:0]   w_e0, w_e1, w_e2, w_e3;
  logic                 w_advb, w_accept, w_va_next, w_vb_next;

  // Per-lane share products, square-scale terms and mask refresh.
  generate
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      logic [3:0] w_a0, w_a1, w_b0, w_b1;
      logic [3:0] w_r0, w_r1, w_r2;
      logic [3:0] w_p0, w_p1, w_p2, w_p3;
      logic [3:0] w_s0, w_s1;

      assign w_a0 = a0[4*l +: 4];
      assign w_a1 = a1[4*l +: 4];
      assign w_b0 = b0[4*l +: 4];
      assign w_b1 = b1[4*l +: 4];
      assign w_r0 = rnd[12*l     +: 4];
      assign w_r1 = rnd[12*l + 4 +: 4];
      assign w_r2 = rnd[12*l + 8 +: 4];

      gf24mul u_p0 (.a(w_a0), .b(w_b0), .p(w_p0));
      gf24mul u_p1 (.a(w_a0), .b(w_b1), .p(w_p1));
      gf24mul u_p2 (.a(w_a1), .b(w_b0), .p(w_p2));
      gf24mul u_p3 (.a(w_a1), .b(w_b1), .p(w_p3));

      if (SQSC) begin : g_sqsc
        sqsc u_s0 (.x(w_a0 ^ w_b0), .y(w_s0));
        sqsc u_s1 (.x(w_a1 ^ w_b1), .y(w_s1));
      end else begin : g_nosqsc
        assign w_s0 = 4'h0;
        assign w_s1 = 4'h0;
      end

      // e0/e1 only see share 0 of a, e2/e3 only share 1: q0 and q1 each
      // depend on a single a-share (non-completeness).
      assign w_e0[4*l +: 4] = w_p0 ^ w_r0 ^ w_s0;
      assign w_e1[4*l +: 4] = w_p1 ^ w_r1;
      assign w_e2[4*l +: 4] = w_p2 ^ w_r0 ^ w_r1 ^ w_r2;
      assign w_e3[4*l +: 4] = w_p3 ^ w_s1 ^ w_r2;
    end
  endgenerate

  // Handshake: B advances when it is empty or being drained this cycle.
  assign w_advb    = r_va & (~r_vb | out_ready);
  assign in_ready  = ~r_va | w_advb;
  assign w_accept  = in_valid & in_ready & rnd_valid;
  assign w_va_next = w_accept | (r_va & ~w_advb);
  assign w_vb_next = w_advb | (r_vb & ~out_ready);

  // Stage A register: capture the four refreshed shares on accept.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_va <= 1'b0;
      r_e0 <= '0;
      r_e1 <= '0;
      r_e2 <= '0;
      r_e3 <= '0;
    end else begin
      r_va <= w_va_next;
      if (w_accept) begin
        r_e0 <= w_e0;
        r_e1 <= w_e1;
        r_e2 <= w_e2;
        r_e3 <= w_e3;
      end
`ifdef TI_STAGE1_PRECHARGE_EN
      else if (!w_va_next) begin
        r_e0 <= '0;
        r_e1 <= '0;
        r_e2 <= '0;
        r_e3 <= '0;
      end
`endif
    end
  end

  // Stage B register: compress four shares to two output shares.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_vb <= 1'b0;
      r_q0 <= '0;
      r_q1 <= '0;
    end else begin
      r_vb <= w_vb_next;
      if (w_advb) begin
        r_q0 <= r_e0 ^ r_e1;
        r_q1 <= r_e2 ^ r_e3;
      end
`ifdef TI_STAGE1_PRECHARGE_EN
      else if (!w_vb_next) begin
        r_q0 <= '0;
        r_q1 <= '0;
      end
`endif
    end
  end

  // The ack is masked during reset so upstream never sees randomness consumed
  // by a stage that is being cleared.
  assign rnd_ack   = w_accept & RSTn;
  assign out_valid = r_vb;
  assign q0        = r_q0;
  assign q1        = r_q1;
  assign busy      = r_va | r_vb;
endmodule

`default_nettype wire

// File: tb/tb_ti_stage1_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ti_stage1_pipe
// Description : Self-checking bench for ti_stage1_pipe. Two instances
//               (SqSc on / off) share stimulus; a queue model predicts
//               flow control and the exact output shares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ti_stage1_pipe;
  localparam int NL = 4;
  localparam int W  = 4 * NL;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RSTn;
  logic            in_valid, rnd_valid, out_ready;
  logic [W-1:0]    a0, a1, b0, b1;
  logic [12*NL-1:0] rnd;

  logic in_ready_s, rnd_ack_s, out_valid_s, busy_s;
  logic in_ready_p, rnd_ack_p, out_valid_p, busy_p;
  logic [W-1:0] q0_s, q1_s, q0_p, q1_p;

  ti_stage1_pipe #(.NLANES(NL), .SQSC(1'b1)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready_s),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rnd(rnd), .rnd_valid(rnd_valid),
    .rnd_ack(rnd_ack_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .q0(q0_s), .q1(q1_s), .busy(busy_s));

  ti_stage1_pipe #(.NLANES(NL), .SQSC(1'b0)) dut_p (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready_p),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rnd(rnd), .rnd_valid(rnd_valid),
    .rnd_ack(rnd_ack_p), .out_valid(out_valid_p), .out_ready(out_ready),
    .q0(q0_p), .q1(q1_p), .busy(busy_p));

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference GF(2^4) arithmetic: shift-and-add, then reduce by x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) if (y[i]) acc ^= (8'(x) << i);
    for (int i = 7; i >= 4; i--) if (acc[i]) acc ^= (8'h13 << (i - 4));
    return acc[3:0];
  endfunction

  function automatic logic [3:0] gsqsc(input logic [3:0] x);
    return gmul(gmul(x, x), 4'h8);
  endfunction

  typedef struct {
    logic [W-1:0] q0s, q1s, q0p, q1p, gs, gp;
    int           age;
  } item_t;

  item_t        mq[$];
  logic [W-1:0] last_q0s, last_q1s, last_q0p, last_q1p;
  logic         exp_ir, exp_ov, exp_acc;

  // Expected output shares of a transfer accepted with the current inputs.
  function automatic item_t make_item();
    item_t it;
    for (int l = 0; l < NL; l++) begin
      logic [3:0] x0, x1, y0, y1, r0, r1;
      x0 = a0[4*l +: 4];  x1 = a1[4*l +: 4];
      y0 = b0[4*l +: 4];  y1 = b1[4*l +: 4];
      r0 = rnd[12*l +: 4]; r1 = rnd[12*l + 4 +: 4];
      it.q0p[4*l +: 4] = gmul(x0, y0) ^ gmul(x0, y1) ^ r0 ^ r1;
      it.q1p[4*l +: 4] = gmul(x1, y0) ^ gmul(x1, y1) ^ r0 ^ r1;
      it.q0s[4*l +: 4] = it.q0p[4*l +: 4] ^ gsqsc(x0 ^ y0);
      it.q1s[4*l +: 4] = it.q1p[4*l +: 4] ^ gsqsc(x1 ^ y1);
      it.gp[4*l +: 4]  = gmul(x0 ^ x1, y0 ^ y1);
      it.gs[4*l +: 4]  = gmul(x0 ^ x1, y0 ^ y1) ^ gsqsc(x0 ^ x1 ^ y0 ^ y1);
    end
    it.age = 1;
    return it;
  endfunction

  // One clock cycle: compare mid-cycle against the model, then advance it.
  task automatic step();
    logic [W-1:0] e0s, e1s, e0p, e1p;
    #1;
    exp_ir  = (mq.size() < 2) || out_ready;
    exp_ov  = (mq.size() > 0) && (mq[0].age >= 2);
    exp_acc = RSTn && in_valid && rnd_valid && exp_ir;
    if (exp_ov) begin
      e0s = mq[0].q0s; e1s = mq[0].q1s; e0p = mq[0].q0p; e1p = mq[0].q1p;
      chk("golden_sqsc", q0_s ^ q1_s, mq[0].gs);
      chk("golden_mul",  q0_p ^ q1_p, mq[0].gp);
    end else begin
`ifdef TI_STAGE1_PRECHARGE_EN
      e0s = '0; e1s = '0; e0p = '0; e1p = '0;
`else
      e0s = last_q0s; e1s = last_q1s; e0p = last_q0p; e1p = last_q1p;
`endif
    end
    chk("in_ready_s",  in_ready_s,  exp_ir);
    chk("in_ready_p",  in_ready_p,  exp_ir);
    chk("rnd_ack_s",   rnd_ack_s,   exp_acc);
    chk("rnd_ack_p",   rnd_ack_p,   exp_acc);
    chk("out_valid_s", out_valid_s, exp_ov);
    chk("out_valid_p", out_valid_p, exp_ov);
    chk("busy_s",      busy_s,      mq.size() > 0);
    chk("busy_p",      busy_p,      mq.size() > 0);
    chk("q0_s", q0_s, e0s);
    chk("q1_s", q1_s, e1s);
    chk("q0_p", q0_p, e0p);
    chk("q1_p", q1_p, e1p);
    @(posedge CLK);
    if (RSTn) begin
      if (exp_ov && out_ready) begin
        last_q0s = mq[0].q0s; last_q1s = mq[0].q1s;
        last_q0p = mq[0].q0p; last_q1p = mq[0].q1p;
        void'(mq.pop_front());
      end
      foreach (mq[i]) mq[i].age++;
      if (exp_acc) mq.push_back(make_item());
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, {out_valid_s, out_valid_p}, 2'b00);
    chk({tag, "_in_ready"},  {in_ready_s, in_ready_p},   2'b11);
    chk({tag, "_busy"},      {busy_s, busy_p},           2'b00);
    chk({tag, "_rnd_ack"},   {rnd_ack_s, rnd_ack_p},     2'b00);
    chk({tag, "_q"},         {q0_s, q1_s, q0_p, q1_p},   64'h0);
  endtask

  task automatic rand_ops();
    a0 = W'($urandom); a1 = W'($urandom);
    b0 = W'($urandom); b1 = W'($urandom);
    rnd = (12*NL)'({$urandom(), $urandom()});
  endtask

  task automatic clear_model();
    mq.delete();
    last_q0s = '0; last_q1s = '0; last_q0p = '0; last_q1p = '0;
  endtask

  initial begin
    RSTn = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; rnd = '0;
    clear_model();
    @(posedge CLK); #1;
    reset_checks("por");
    step(); step();
    RSTn = 1'b1;
    step();

    // Zero operands: output is pure mask, r0^r1 = 3^5 = 6 in every lane.
    rnd = {NL{12'hA53}}; in_valid = 1'b1; rnd_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("zero_out_valid", out_valid_s, 1'b1);
    chk("zero_q0_s", q0_s, 16'h6666);
    chk("zero_q1_s", q1_s, 16'h6666);
    chk("zero_q0_p", q0_p, 16'h6666);
    step(); step();

    // a=2, b=9 in share 0, unmasked: 2*9=1, SqSc(0xB)=4.
    a0 = {NL{4'h2}}; a1 = '0; b0 = {NL{4'h9}}; b1 = '0; rnd = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("lit_q0_s", q0_s, 16'h5555);
    chk("lit_q1_s", q1_s, 16'h0000);
    chk("lit_q0_p", q0_p, 16'h1111);
    chk("lit_q1_p", q1_p, 16'h0000);
    step(); step();

    // Back-to-back random transfers at full rate.
    in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_ops();
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // No randomness: nothing may be accepted.
    rand_ops(); in_valid = 1'b1; rnd_valid = 1'b0;
    repeat (5) step();
    rnd_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Fill both stages with the output stalled, then drain while accepting.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_ops(); step();
    rand_ops(); step();
    rand_ops();
    repeat (4) step();
    out_ready = 1'b1;
    step();
    rand_ops(); step();
    in_valid = 1'b0;
    repeat (4) step();

    // Random mixed handshake; operands held until accepted.
    rand_ops();
    for (int i = 0; i < 1500; i++) begin
      if (exp_acc || !in_valid) rand_ops();
      in_valid  = ($urandom_range(0, 3) != 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; rnd_valid = 1'b1;
    repeat (4) step();

    // Reset while both stages are full.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_ops(); step();
    rand_ops(); step();
    chk("full_busy", {busy_s, in_ready_s}, 2'b10);
    #2;
    RSTn = 1'b0;
    #1;
    reset_checks("async");
    clear_model();
    step(); step();
    RSTn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    rand_ops(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("drained", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
`default_nettype wire
